decode_issue_stage: RTL and testbench

DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

---
 rtl/decode_issue_if.sv | 51 +++++
 rtl/decode_issue_stage.sv | 97 +++++++++
 tb/tb_decode_issue_stage.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_if.sv
// Handshake and payload bundle between the decode front end, the decode/issue
// stage and the issue consumer, plus the writeback, stack pointer and stall observation signals.
interface decode_issue_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [31:0]       in_inst;
    logic [REG_AW-1:0] in_src0;
    logic [REG_AW-1:0] in_src1;
    logic              in_src0_en;
    logic              in_src1_en;
    logic [REG_AW-1:0] in_dst;
    logic              in_dst_en;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [31:0]       out_inst;
    logic [REG_AW-1:0] out_src0;
    logic [REG_AW-1:0] out_src1;
    logic [REG_AW-1:0] out_dst;
    logic              out_dst_en;
    logic [CTRL_W-1:0] out_ctrl;

    logic              wb_en;
    logic [REG_AW-1:0] wb_reg;
    logic              sp_we;
    logic [XLEN-1:0]   sp_in;
    logic [XLEN-1:0]   sp_out;
    logic [31:0]       stall_cnt;

    modport master (
        output in_valid, in_pc, in_inst, in_src0, in_src1, in_src0_en, in_src1_en,
               in_dst, in_dst_en, in_ctrl, flush, out_ready, wb_en, wb_reg, sp_we, sp_in,
        input  in_ready, out_valid, out_pc, out_inst, out_src0, out_src1, out_dst,
               out_dst_en, out_ctrl, sp_out, stall_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_src0, in_src1, in_src0_en, in_src1_en,
               in_dst, in_dst_en, in_ctrl, flush, out_ready, wb_en, wb_reg, sp_we, sp_in,
        output in_ready, out_valid, out_pc, out_inst, out_src0, out_src1, out_dst,
               out_dst_en, out_ctrl, sp_out, stall_cnt
    );
endinterface

// File: rtl/decode_issue_stage.sv
// Single-entry decode/issue register with a per-register pending scoreboard.
// Stalls on RAW/WAW hazards, supports flush, and tracks stack pointer and stall cycles.
module decode_issue_stage #(
    parameter int              XLEN      = 32,
    parameter int              REG_AW    = 5,
    parameter int              CTRL_W    = 16,
    parameter logic [XLEN-1:0] SP_RESET  = XLEN'(32'h0000_3000),
    parameter bit              BYPASS_WB = 1'b1,
    parameter bit              R0_ZERO   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    decode_issue_if.slave bus
);
    localparam int NREG = 2 ** REG_AW;

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic [NREG-1:0] busy;
    logic            hazard;
    logic            accept;
    logic            issue;
    logic            stall_inc;

    // A register is busy if it is still pending (unless being written back this
    // cycle with bypass enabled) or if it is the destination of the held instruction.
    always_comb begin
        busy = '0;
        for (int r = 0; r < NREG; r++) begin
            busy[r] = (pend[r] && !(BYPASS_WB && bus.wb_en && (bus.wb_reg == REG_AW'(r))))
                   || (bus.out_valid && bus.out_dst_en && (bus.out_dst == REG_AW'(r)));
        end
        if (R0_ZERO) begin
            busy[0] = 1'b0;
        end
    end

    assign hazard = (bus.in_src0_en && busy[bus.in_src0])
                 || (bus.in_src1_en && busy[bus.in_src1])
                 || (bus.in_dst_en  && busy[bus.in_dst]);

    assign bus.in_ready = !rst && !hazard && !bus.flush && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign issue        = bus.out_valid && bus.out_ready;
    assign stall_inc    = bus.in_valid && hazard && !bus.flush;

    // Set is applied after clear so an issuing write to a register wins over a
    // writeback to the same register in the same cycle.
    always_comb begin
        pend_nxt = pend;
        if (bus.wb_en) begin
            pend_nxt[bus.wb_reg] = 1'b0;
        end
        if (issue && bus.out_dst_en && !(R0_ZERO && (bus.out_dst == '0))) begin
            pend_nxt[bus.out_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.out_pc     <= '0;
            bus.out_inst   <= '0;
            bus.out_src0   <= '0;
            bus.out_src1   <= '0;
            bus.out_dst    <= '0;
            bus.out_dst_en <= 1'b0;
            bus.out_ctrl   <= '0;
            pend           <= '0;
            bus.sp_out     <= SP_RESET;
            bus.stall_cnt  <= '0;
        end else begin
            if (accept) begin
                bus.out_valid  <= 1'b1;
                bus.out_pc     <= bus.in_pc;
                bus.out_inst   <= bus.in_inst;
                bus.out_src0   <= bus.in_src0;
                bus.out_src1   <= bus.in_src1;
                bus.out_dst    <= bus.in_dst;
                bus.out_dst_en <= bus.in_dst_en;
                bus.out_ctrl   <= bus.in_ctrl;
            end else if (issue || bus.flush) begin
                bus.out_valid  <= 1'b0;
            end

            pend <= pend_nxt;

            if (bus.sp_we) begin
                bus.sp_out <= bus.sp_in;
            end

            if (stall_inc && (bus.stall_cnt != 32'hFFFF_FFFF)) begin
                bus.stall_cnt <= bus.stall_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed self-checking bench for decode_issue_stage: default instance plus an
// R0_ZERO=1 / BYPASS_WB=0 instance.
module tb_decode_issue_stage;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    decode_issue_if #(.XLEN(32), .REG_AW(5), .CTRL_W(16)) bus ();
    decode_issue_if #(.XLEN(32), .REG_AW(5), .CTRL_W(16)) bus2 ();

    decode_issue_stage dut (.clk(clk), .rst(rst), .bus(bus));
    decode_issue_stage #(.BYPASS_WB(1'b0), .R0_ZERO(1'b1)) dut_r0 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_pc = '0; bus.in_inst = '0; bus.in_src0 = '0; bus.in_src1 = '0;
        bus.in_src0_en = 0; bus.in_src1_en = 0; bus.in_dst = '0; bus.in_dst_en = 0; bus.in_ctrl = '0;
        bus.flush = 0; bus.out_ready = 0; bus.wb_en = 0; bus.wb_reg = '0; bus.sp_we = 0; bus.sp_in = '0;
        bus2.in_valid = 0; bus2.in_pc = '0; bus2.in_inst = '0; bus2.in_src0 = '0; bus2.in_src1 = '0;
        bus2.in_src0_en = 0; bus2.in_src1_en = 0; bus2.in_dst = '0; bus2.in_dst_en = 0; bus2.in_ctrl = '0;
        bus2.flush = 0; bus2.out_ready = 0; bus2.wb_en = 0; bus2.wb_reg = '0; bus2.sp_we = 0; bus2.sp_in = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready); end
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL rst_out_pc got=%h exp=0", bus.out_pc); end
        checks++; if (bus.sp_out !== 32'h0000_3000) begin errors++; $display("FAIL rst_sp_out got=%h exp=00003000", bus.sp_out); end
        checks++; if (bus.stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt got=%0d exp=0", bus.stall_cnt); end
        rst = 0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%0b exp=1", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        idle();
        bus.out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1;
            bus.in_pc    = pcs[i];
            bus.in_inst  = 32'hA000_0000 + 32'(i);
            bus.in_ctrl  = 16'h0010 + 16'(i);
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%0b exp=1", i, bus.in_ready); end
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== pcs[i]) begin
                errors++; $display("FAIL b2b_out[%0d] got valid=%0b pc=%h exp valid=1 pc=%h", i, bus.out_valid, bus.out_pc, pcs[i]);
            end
        end
        bus.in_valid = 0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.stall_cnt !== 32'd0) begin errors++; $display("FAIL b2b_stall_cnt got=%0d exp=0", bus.stall_cnt); end
    endtask

    task automatic test_raw();
        idle();
        bus.out_ready = 1;
        bus.in_valid = 1; bus.in_pc = 32'h500; bus.in_dst = 5; bus.in_dst_en = 1;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_dst !== 5'd5) begin
            errors++; $display("FAIL raw_first got valid=%0b dst=%0d exp valid=1 dst=5", bus.out_valid, bus.out_dst);
        end
        bus.in_pc = 32'h504; bus.in_dst_en = 0; bus.in_dst = 0; bus.in_src0 = 5; bus.in_src0_en = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall[%0d] got=%0b exp=0", i, bus.in_ready); end
            tick();
        end
        bus.wb_en = 1; bus.wb_reg = 5;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL raw_bypass_ready got=%0b exp=1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h504) begin
            errors++; $display("FAIL raw_accept got valid=%0b pc=%h exp valid=1 pc=504", bus.out_valid, bus.out_pc);
        end
        checks++; if (bus.stall_cnt !== 32'd3) begin errors++; $display("FAIL raw_stall_cnt got=%0d exp=3", bus.stall_cnt); end
        bus.wb_en = 0; bus.in_valid = 0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL raw_drain got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL raw_pend_cleared got=%0b exp=1", bus.in_ready); end
    endtask

    task automatic test_backpressure();
        idle();
        bus.in_valid = 1; bus.in_pc = 32'h200; bus.in_inst = 32'hDEAD_BEEF; bus.in_ctrl = 16'hABCD;
        bus.in_src1 = 3; bus.in_dst = 4;
        tick();
        bus.in_pc = 32'h204; bus.in_inst = 32'h1234_5678; bus.in_ctrl = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%0b exp=0", i, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 || bus.out_inst !== 32'hDEAD_BEEF || bus.out_ctrl !== 16'hABCD) begin
                errors++; $display("FAIL bp_stable[%0d] got valid=%0b pc=%h inst=%h ctrl=%h exp 1 200 deadbeef abcd",
                                   i, bus.out_valid, bus.out_pc, bus.out_inst, bus.out_ctrl);
            end
            tick();
        end
        bus.out_ready = 1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b exp=1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h204 || bus.out_ctrl !== 16'h5555) begin
            errors++; $display("FAIL bp_next got valid=%0b pc=%h ctrl=%h exp 1 204 5555", bus.out_valid, bus.out_pc, bus.out_ctrl);
        end
        bus.in_valid = 0;
        tick();
        checks++; if (bus.stall_cnt !== 32'd3) begin errors++; $display("FAIL bp_stall_cnt got=%0d exp=3", bus.stall_cnt); end
    endtask

    task automatic test_flush();
        idle();
        bus.in_valid = 1; bus.in_pc = 32'h300; bus.in_dst = 7; bus.in_dst_en = 1;
        tick();
        bus.flush = 1; bus.in_pc = 32'h304; bus.in_dst_en = 0; bus.in_src0 = 7; bus.in_src0_en = 1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%0b exp=0", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%0b exp=0", bus.out_valid); end
        bus.flush = 0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_pend7_clear got=%0b exp=1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h304) begin
            errors++; $display("FAIL flush_after_accept got valid=%0b pc=%h exp 1 304", bus.out_valid, bus.out_pc);
        end
        checks++; if (bus.stall_cnt !== 32'd3) begin errors++; $display("FAIL flush_stall_cnt got=%0d exp=3", bus.stall_cnt); end
        bus.in_valid = 0; bus.out_ready = 1;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drain got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_set_wins();
        idle();
        bus.out_ready = 1;
        bus.in_valid = 1; bus.in_pc = 32'h900; bus.in_dst = 9; bus.in_dst_en = 1;
        tick();
        bus.in_valid = 0; bus.in_dst_en = 0; bus.wb_en = 1; bus.wb_reg = 9;
        tick();
        bus.wb_en = 0; bus.in_src0 = 9; bus.in_src0_en = 1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL setwins_pend9 got=%0b exp=0", bus.in_ready); end
        bus.wb_en = 1;
        tick();
        bus.wb_en = 0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL setwins_cleared got=%0b exp=1", bus.in_ready); end
    endtask

    task automatic test_sp();
        idle();
        bus.sp_we = 1; bus.sp_in = 32'h0000_2FFC;
        tick();
        checks++; if (bus.sp_out !== 32'h0000_2FFC) begin errors++; $display("FAIL sp_load got=%h exp=00002ffc", bus.sp_out); end
        bus.sp_we = 0; bus.sp_in = 32'h0000_1111;
        tick();
        checks++; if (bus.sp_out !== 32'h0000_2FFC) begin errors++; $display("FAIL sp_hold got=%h exp=00002ffc", bus.sp_out); end
    endtask

    task automatic test_r0_zero();
        idle();
        bus2.out_ready = 1;
        bus2.in_valid = 1; bus2.in_pc = 32'h600; bus2.in_dst = 0; bus2.in_dst_en = 1;
        tick();
        bus2.in_pc = 32'h604; bus2.in_dst_en = 0; bus2.in_src0 = 0; bus2.in_src0_en = 1;
        #1;
        checks++; if (bus2.in_ready !== 1'b1) begin errors++; $display("FAIL r0_no_stall got=%0b exp=1", bus2.in_ready); end
        tick();
        checks++; if (bus2.out_valid !== 1'b1 || bus2.out_pc !== 32'h604) begin
            errors++; $display("FAIL r0_accept got valid=%0b pc=%h exp 1 604", bus2.out_valid, bus2.out_pc);
        end
        bus2.in_valid = 0;
        tick();
        checks++; if (bus2.in_ready !== 1'b1) begin errors++; $display("FAIL r0_pend0_zero got=%0b exp=1", bus2.in_ready); end
        bus2.in_src0_en = 0; bus2.in_valid = 1; bus2.in_pc = 32'h608; bus2.in_dst = 6; bus2.in_dst_en = 1;
        tick();
        bus2.in_valid = 0; bus2.in_dst_en = 0;
        tick();
        bus2.in_src0 = 6; bus2.in_src0_en = 1; bus2.wb_en = 1; bus2.wb_reg = 6;
        #1;
        checks++; if (bus2.in_ready !== 1'b0) begin errors++; $display("FAIL nobypass_wb_cycle got=%0b exp=0", bus2.in_ready); end
        tick();
        bus2.wb_en = 0;
        #1;
        checks++; if (bus2.in_ready !== 1'b1) begin errors++; $display("FAIL nobypass_after_wb got=%0b exp=1", bus2.in_ready); end
        checks++; if (bus2.stall_cnt !== 32'd0) begin errors++; $display("FAIL r0_stall_cnt got=%0d exp=0", bus2.stall_cnt); end
    endtask

    task automatic test_reset_midop();
        idle();
        bus.out_ready = 1;
        bus.in_valid = 1; bus.in_pc = 32'h400; bus.in_dst = 3; bus.in_dst_en = 1;
        tick();
        bus.in_valid = 0; bus.in_dst_en = 0;
        tick();
        bus.in_src0 = 3; bus.in_src0_en = 1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midop_pend3_set got=%0b exp=0", bus.in_ready); end
        bus.in_src0_en = 0; bus.out_ready = 0; bus.in_valid = 1; bus.in_pc = 32'h404;
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midop_held got=%0b exp=1", bus.out_valid); end
        rst = 1; bus.sp_we = 1; bus.sp_in = 32'h1234; bus.out_ready = 1; bus.wb_en = 1; bus.wb_reg = 8;
        tick();
        rst = 0; idle();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin
            errors++; $display("FAIL midop_rst_out got valid=%0b pc=%h exp 0 0", bus.out_valid, bus.out_pc);
        end
        checks++; if (bus.sp_out !== 32'h0000_3000 || bus.stall_cnt !== 32'd0) begin
            errors++; $display("FAIL midop_rst_regs got sp=%h stall=%0d exp 00003000 0", bus.sp_out, bus.stall_cnt);
        end
        bus.in_src0 = 3; bus.in_src0_en = 1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midop_pend3_cleared got=%0b exp=1", bus.in_ready); end
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_back_to_back();
        test_raw();
        test_backpressure();
        test_flush();
        test_set_wins();
        test_sp();
        test_r0_zero();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
